// File: rtl/pwm_multi_gen.sv
// pwm_multi_gen: multi-channel PWM from one counter and a clock-enable prescaler.
// Define PWM_SHADOW_EN to double-buffer duty writes and sample period at wrap.
module pwm_multi_gen #(
    parameter int  CHANNELS  = 4,
    parameter int  WIDTH     = 8,
    parameter int  PSC_WIDTH = 8,
    localparam int CW        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic [PSC_WIDTH-1:0] prescale,
    input  logic [WIDTH-1:0]     period,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [CW-1:0]        wr_chan,
    input  logic [WIDTH-1:0]     wr_duty,
    output logic [CHANNELS-1:0]  pwm_out,
    output logic                 period_tick
);

    logic                 rst_n_q;
    logic [PSC_WIDTH-1:0] psc_cnt;
    logic [WIDTH-1:0]     cnt;
    logic [WIDTH-1:0]     period_act;
    logic [WIDTH-1:0]     duty_act [CHANNELS];
    logic                 tick;
    logic                 wrap;
    logic                 wr_fire;
    logic [CHANNELS-1:0]  wr_sel;

    assign wr_ready = rst_n_q & ena;
    assign wr_fire  = wr_valid & wr_ready;

    // All-ones also ticks so a prescale lowered below psc_cnt cannot stall
    assign tick = ena & ((psc_cnt == prescale) | (&psc_cnt));

`ifdef PWM_SHADOW_EN
    assign wrap = tick & (cnt == period_act);
`else
    assign wrap = tick & (cnt >= period_act);
`endif

    // Channel numbers at or above CHANNELS match nothing and are dropped
    always_comb begin
        wr_sel = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            wr_sel[i] = wr_fire & (wr_chan == CW'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rst_n_q     <= 1'b0;
            psc_cnt     <= '0;
            cnt         <= '0;
            period_tick <= 1'b0;
        end else begin
            rst_n_q     <= 1'b1;
            period_tick <= wrap;
            if (tick) begin
                psc_cnt <= '0;
                cnt     <= wrap ? '0 : cnt + WIDTH'(1);
            end else if (ena) begin
                psc_cnt <= psc_cnt + PSC_WIDTH'(1);
            end
        end
    end

`ifdef PWM_SHADOW_EN
    logic [WIDTH-1:0] duty_shd [CHANNELS];

    // Commit reads the shadow before any same-cycle write lands in it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            period_act <= '1;
            for (int i = 0; i < CHANNELS; i++) begin
                duty_shd[i] <= '0;
                duty_act[i] <= '0;
            end
        end else begin
            if (wrap) begin
                period_act <= period;
            end
            for (int i = 0; i < CHANNELS; i++) begin
                if (wr_sel[i]) begin
                    duty_shd[i] <= wr_duty;
                end
                if (wrap) begin
                    duty_act[i] <= duty_shd[i];
                end
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            period_act <= '1;
            for (int i = 0; i < CHANNELS; i++) begin
                duty_act[i] <= '0;
            end
        end else begin
            period_act <= period;
            for (int i = 0; i < CHANNELS; i++) begin
                if (wr_sel[i]) begin
                    duty_act[i] <= wr_duty;
                end
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pwm_out <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                pwm_out[i] <= ena & (cnt < duty_act[i]);
            end
        end
    end

endmodule

// File: tb/tb_pwm_multi_gen.sv
// tb_pwm_multi_gen: directed stimulus; per-period high counts and lengths
// are queued by the stimulus and checked by a monitor at each period_tick.
module tb_pwm_multi_gen;

`ifdef PWM_SHADOW_EN
    localparam bit SHADOW = 1'b1;
`else
    localparam bit SHADOW = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] prescale;
    logic [7:0] period;
    logic       wr_valid;
    logic       wr_ready;
    logic [1:0] wr_chan;
    logic [7:0] wr_duty;
    logic [3:0] pwm_out;
    logic       period_tick;

    pwm_multi_gen #(
        .CHANNELS (4),
        .WIDTH    (8),
        .PSC_WIDTH(8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .prescale   (prescale),
        .period     (period),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_chan    (wr_chan),
        .wr_duty    (wr_duty),
        .pwm_out    (pwm_out),
        .period_tick(period_tick)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int len;
        int h0;
        int h1;
        int h2;
        int h3;
    } win_t;

    win_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   win_no   = 0;
    int   acc_len  = 0;
    int   acc_hi [4];
    logic rst_q    = 1'b0;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic expect_win(input int l, input int a, input int b,
                              input int c, input int d);
        exp_q.push_back('{len: l, h0: a, h1: b, h2: c, h3: d});
    endtask

    // Monitor: one window runs from the cycle after a tick up to the next tick
    always @(posedge clk) rst_q <= rst_n;

    always @(negedge clk) begin
        win_t e;
        if (!rst_q) begin
            acc_len = 0;
            for (int i = 0; i < 4; i++) acc_hi[i] = 0;
        end else begin
            acc_len++;
            for (int i = 0; i < 4; i++) acc_hi[i] += int'(pwm_out[i]);
            if (period_tick) begin
                win_no++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL win%0d unexpected tick got=len%0d exp=none",
                             win_no, acc_len);
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("win%0d len", win_no), acc_len, e.len);
                    chk($sformatf("win%0d hi0", win_no), acc_hi[0], e.h0);
                    chk($sformatf("win%0d hi1", win_no), acc_hi[1], e.h1);
                    chk($sformatf("win%0d hi2", win_no), acc_hi[2], e.h2);
                    chk($sformatf("win%0d hi3", win_no), acc_hi[3], e.h3);
                end
                acc_len = 0;
                for (int i = 0; i < 4; i++) acc_hi[i] = 0;
            end
        end
    end

    task automatic wait_tick(input int budget);
        int n;
        bit seen;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < budget) begin
            @(negedge clk);
            wr_valid = 1'b0;
            n++;
            if (period_tick) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL tick_timeout got=none exp=tick within %0d", budget);
        end
    endtask

    task automatic wr(input int c, input int d);
        wr_chan  = 2'(c);
        wr_duty  = 8'(d);
        wr_valid = 1'b1;
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        ena      = 1'b1;
        prescale = 8'd0;
        period   = 8'd9;
        wr_valid = 1'b0;
        wr_chan  = 2'd0;
        wr_duty  = 8'd0;
        for (int i = 0; i < 4; i++) acc_hi[i] = 0;

        repeat (3) @(negedge clk);
        chk("rst pwm", int'(pwm_out), 0);
        chk("rst tick", int'(period_tick), 0);
        chk("rst ready", int'(wr_ready), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready rise", int'(wr_ready), 1);

        wr(0, 0);
        wr(1, 3);
        wr(2, 10);
        wr(3, 255);
        if (SHADOW) expect_win(256, 0, 0, 0, 0);
        else        expect_win(10, 0, 0, 6, 5);
        wait_tick(300);
        expect_win(10, 0, 3, 10, 10);
        wait_tick(100);
        expect_win(10, 0, 3, 10, 10);
        wait_tick(100);

        // duty 3 -> 7 mid-period
        repeat (4) @(negedge clk);
        wr(1, 7);
        expect_win(10, 0, SHADOW ? 3 : 5, 10, 10);
        wait_tick(100);
        expect_win(10, 0, 7, 10, 10);
        wait_tick(100);

        // write accepted on the wrap edge
        repeat (9) @(negedge clk);
        wr_chan  = 2'd1;
        wr_duty  = 8'd2;
        wr_valid = 1'b1;
        expect_win(10, 0, 7, 10, 10);
        wait_tick(100);
        expect_win(10, 0, SHADOW ? 7 : 2, 10, 10);
        wait_tick(100);
        expect_win(10, 0, 2, 10, 10);
        wait_tick(100);

        // ena low for 5 cycles mid-period
        repeat (5) @(negedge clk);
        ena = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("ena_lo pwm c%0d", k), int'(pwm_out), 0);
            chk($sformatf("ena_lo ready c%0d", k), int'(wr_ready), 0);
            chk($sformatf("ena_lo tick c%0d", k), int'(period_tick), 0);
        end
        ena = 1'b1;
        expect_win(15, 0, 2, 10, 10);
        wait_tick(100);
        expect_win(10, 0, 2, 10, 10);
        wait_tick(100);

        // prescale 2, period 3
        prescale = 8'd2;
        period   = 8'd3;
        if (SHADOW) expect_win(30, 0, 6, 30, 30);
        else        expect_win(12, 0, 6, 12, 12);
        wait_tick(100);
        expect_win(12, 0, 6, 12, 12);
        wait_tick(100);
        expect_win(12, 0, 6, 12, 12);
        wait_tick(100);

        // one-cycle reset mid-period with a pending write
        repeat (3) @(negedge clk);
        wr(1, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst pwm", int'(pwm_out), 0);
        chk("mid_rst tick", int'(period_tick), 0);
        chk("mid_rst ready", int'(wr_ready), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rst ready rise", int'(wr_ready), 1);
        if (SHADOW) expect_win(768, 0, 0, 0, 0);
        else        expect_win(12, 0, 0, 0, 0);
        wait_tick(1000);
        wr(0, 1);
        expect_win(12, SHADOW ? 0 : 2, 0, 0, 0);
        wait_tick(100);
        expect_win(12, 3, 0, 0, 0);
        wait_tick(100);

        prescale = 8'd0;
        period   = 8'd9;
`ifdef PWM_SHADOW_EN
        expect_win(4, 1, 0, 0, 0);
        wait_tick(100);
        expect_win(10, 1, 0, 0, 0);
        wait_tick(100);
`else
        expect_win(10, 1, 0, 0, 0);
        wait_tick(100);
        // period 9 -> 2 so that period_act=2 while cnt=6
        repeat (5) @(negedge clk);
        period = 8'd2;
        expect_win(7, 1, 0, 0, 0);
        wait_tick(100);
        expect_win(3, 1, 0, 0, 0);
        wait_tick(100);
`endif

        repeat (2) @(negedge clk);
        chk("queue drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
